// File: rtl/pulse_cnt_pkg.sv
// Shared types and sizing helpers for the pulse counter front end.
package pulse_cnt_pkg;

  localparam int NCH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_LOW_CHK  = 2'd1,
    ST_HIGH     = 2'd2,
    ST_HIGH_CHK = 2'd3
  } deb_state_t;

  function automatic int cnt_w(input int deb_cnt);
    return $clog2(deb_cnt + 1);
  endfunction

endpackage

// File: rtl/pic_channel.sv
// One input channel: synchroniser, debounce FSM, edge strobes and sticky glitch flag.
module pic_channel
  import pulse_cnt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  input  logic clr_glitch,
  output logic level,
  output logic rise,
  output logic rise_nxt,
  output logic fall,
  output logic glitch
);

  localparam int CW = cnt_w(DEB_CNT);
  localparam logic [CW-1:0] DEB_M1 = CW'(DEB_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  deb_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   rise_q, rise_d, fall_q, fall_d;
  logic                   glitch_q, glitch_d, gset;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    gset    = 1'b0;
    if (en) begin
      case (state_q)
        ST_LOW: if (s) begin
          if (DEB_CNT == 1) begin
            state_d = ST_HIGH;
            rise_d  = 1'b1;
          end else begin
            state_d = ST_LOW_CHK;
            cnt_d   = CW'(1);
          end
        end
        ST_LOW_CHK: if (s) begin
          if (cnt_q == DEB_M1) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_LOW;
          cnt_d   = '0;
          gset    = 1'b1;
        end
        ST_HIGH: if (!s) begin
          if (DEB_CNT == 1) begin
            state_d = ST_LOW;
            fall_d  = 1'b1;
          end else begin
            state_d = ST_HIGH_CHK;
            cnt_d   = CW'(1);
          end
        end
        ST_HIGH_CHK: if (!s) begin
          if (cnt_q == DEB_M1) begin
            state_d = ST_LOW;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          gset    = 1'b1;
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      endcase
    end
    // a new rejection in the same cycle as a clear keeps the flag set
    glitch_d = gset | (glitch_q & ~clr_glitch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign level    = (state_q == ST_HIGH) || (state_q == ST_HIGH_CHK);
  assign rise     = rise_q;
  assign rise_nxt = rise_d;
  assign fall     = fall_q;
  assign glitch   = glitch_q;

endmodule

// File: rtl/pulse_input_conditioner.sv
// Multichannel pulse input conditioner: NCH independent debounced channels plus any_rise.
module pulse_input_conditioner
  import pulse_cnt_pkg::*;
#(
  parameter int NCH         = NCH_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT     = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [NCH-1:0] din,
  input  logic [NCH-1:0] clr_glitch,
  output logic [NCH-1:0] level,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic           any_rise,
  output logic [NCH-1:0] glitch
);

  logic [NCH-1:0] rise_nxt;
  logic           any_rise_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pic_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CNT    (DEB_CNT)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .din       (din[g]),
      .clr_glitch(clr_glitch[g]),
      .level     (level[g]),
      .rise      (rise[g]),
      .rise_nxt  (rise_nxt[g]),
      .fall      (fall[g]),
      .glitch    (glitch[g])
    );
  end

  // built from next-state strobes so it lines up with rise
  always_ff @(posedge clk) begin
    if (rst) any_rise_q <= 1'b0;
    else     any_rise_q <= |rise_nxt;
  end

  assign any_rise = any_rise_q;

endmodule

// File: tb/tb_pulse_input_conditioner.sv
// Scoreboard bench: directed stimulus queues expected strobe events, a negedge monitor checks them.
module tb_pulse_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [7:0] din = 8'h00;
  logic [7:0] clr_glitch = 8'h00;
  logic [7:0] level, rise, fall, glitch;
  logic       any_rise;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [7:0] r;
    logic [7:0] f;
    logic       a;
  } ev_t;
  ev_t exp_q[$];

  pulse_input_conditioner dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .clr_glitch(clr_glitch),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .any_rise  (any_rise),
    .glitch    (glitch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // strobe expected dly posedges after now (dly=6: sample edge + 5)
  task automatic expect_ev(input int dly, input logic [7:0] r, input logic [7:0] f);
    ev_t e;
    e.cyc = cyc + dly;
    e.r   = r;
    e.f   = f;
    e.a   = (r != 8'h00);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rise != 8'h00 || fall != 8'h00 || any_rise != 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: cyc %0d rise %h fall %h any_rise %b, none expected",
                 cyc, rise, fall, any_rise);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.r !== rise || e.f !== fall || e.a !== any_rise) begin
          failures++;
          $display("FAIL strobe_event: got cyc %0d rise %h fall %h any %b, expected cyc %0d rise %h fall %h any %b",
                   cyc, rise, fall, any_rise, e.cyc, e.r, e.f, e.a);
        end
      end
    end
  end

  initial begin
    // power-up with inputs high through reset
    din = 8'hFF;
    step(3);
    chk("reset_level", level, 8'h00);
    chk("reset_rise", rise, 8'h00);
    chk("reset_glitch", glitch, 8'h00);
    chk("reset_any_rise", {7'b0, any_rise}, 8'h00);
    rst = 1'b0;
    expect_ev(6, 8'hFF, 8'h00);
    step(12);
    chk("powerup_level", level, 8'hFF);

    din = 8'h00;
    expect_ev(6, 8'h00, 8'hFF);
    step(12);
    chk("all_low_level", level, 8'h00);

    // clean edge on channel 0
    din[0] = 1'b1;
    expect_ev(6, 8'h01, 8'h00);
    step(10);
    chk("clean_level", level, 8'h01);
    din[0] = 1'b0;
    expect_ev(6, 8'h00, 8'h01);
    step(10);

    // 2-cycle glitch on channel 3, then clear
    din[3] = 1'b1;
    step(2);
    din[3] = 1'b0;
    step(8);
    chk("glitch_set", glitch, 8'h08);
    chk("glitch_level", level, 8'h00);
    clr_glitch[3] = 1'b1;
    step(1);
    clr_glitch[3] = 1'b0;
    chk("glitch_clr", glitch, 8'h00);

    // rejection coincident with clear: set wins
    din[3] = 1'b1;
    step(2);
    din[3] = 1'b0;
    step(2);
    clr_glitch[3] = 1'b1;
    step(1);
    clr_glitch[3] = 1'b0;
    chk("glitch_set_wins", glitch, 8'h08);
    clr_glitch[3] = 1'b1;
    step(1);
    clr_glitch[3] = 1'b0;
    chk("glitch_clr2", glitch, 8'h00);
    step(4);

    // freeze at cnt=2 on channel 2
    din[2] = 1'b1;
    step(4);
    en = 1'b0;
    step(20);
    chk("en_hold_level", level, 8'h00);
    en = 1'b1;
    expect_ev(2, 8'h04, 8'h00);
    step(6);
    chk("en_resume_level", level, 8'h04);
    din[2] = 1'b0;
    expect_ev(6, 8'h00, 8'h04);
    step(10);

    // simultaneous rise on ch1 and fall on ch6
    din[6] = 1'b1;
    expect_ev(6, 8'h40, 8'h00);
    step(10);
    din = 8'h02;
    expect_ev(6, 8'h02, 8'h40);
    step(10);
    chk("concurrent_level", level, 8'h02);
    din = 8'h00;
    expect_ev(6, 8'h00, 8'h02);
    step(10);

    // reset lands on what would be the accepting edge
    din[5] = 1'b1;
    step(5);
    rst = 1'b1;
    din = 8'h00;
    step(2);
    chk("midqual_reset_level", level, 8'h00);
    chk("midqual_reset_glitch", glitch, 8'h00);
    rst = 1'b0;
    step(10);
    chk("post_reset_level", level, 8'h00);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: %0d expected strobe events never seen", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
